// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch FSM state type.
//   XLEN           datapath width
//   NOP_INSTR      canonical RV32I NOP (addi x0,x0,0)
//   fetch_state_e  fetch FSM states BOOT/RUN/HALTED
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF/ID handshake bundle between fetch (master) and decode (slave).
//   id_valid     IF/ID holds a live instruction
//   id_ready     decode accepts IF/ID this cycle
//   id_pc        PC of id_instr
//   id_instr     fetched instruction
//   id_pc_plus4  id_pc + 4 (link value)
//   id_misalign  misaligned-fetch flag (only with FETCH_MISALIGN_TRAP_EN)
interface fetch_stage_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            id_misalign;
    modport master (output id_valid, id_pc, id_instr, id_pc_plus4, id_misalign, input id_ready);
    modport slave  (input id_valid, id_pc, id_instr, id_pc_plus4, id_misalign, output id_ready);
`else
    modport master (output id_valid, id_pc, id_instr, id_pc_plus4, input id_ready);
    modport slave  (input id_valid, id_pc, id_instr, id_pc_plus4, output id_ready);
`endif
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load and clear (clear wins).
//   clk, rst_n      clock, async active-low reset
//   load_i          capture pc/instr/pc_plus4 and set valid
//   clr_i           drop valid (redirect kill or accept while halted)
//   pc_i/instr_i/pc_plus4_i  data to capture
//   valid_o/pc_o/instr_o/pc_plus4_o  registered IF/ID contents
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_plus4_o
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_o    <= 1'b0;
            pc_o       <= '0;
            instr_o    <= NOP_INSTR;
            pc_plus4_o <= '0;
        end else if (clr_i) begin
            valid_o    <= 1'b0;
        end else if (load_i) begin
            valid_o    <= 1'b1;
            pc_o       <= pc_i;
            instr_o    <= instr_i;
            pc_plus4_o <= pc_plus4_i;
        end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC register, BOOT/RUN/HALTED FSM and IF/ID handshake.
//   clk, rst_n        clock, async active-low reset
//   imem_addr_o       byte address to async-read instruction memory (= pc_q)
//   imem_instr_i      instruction word for imem_addr_o, same cycle
//   redirect_valid_i  execute redirect request (ignored in BOOT)
//   redirect_pc_i     redirect target
//   halt_req_i        level-sensitive halt request
//   halted_o          FSM is in HALTED
//   id_if             IF/ID handshake (master side)
//   Macro FETCH_MISALIGN_TRAP_EN: keep raw redirect targets and trap misaligned fetches
//   with a NOP plus id_misalign, then halt; otherwise targets are word-aligned on load.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_req_i,
    output logic            halted_o,
    fetch_stage_if.master   id_if
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, target;
    logic            redir, load, clr, mis;

    assign redir = redirect_valid_i && state_q != BOOT;
    assign load  = state_q == RUN && !redir && (!id_if.id_valid || id_if.id_ready);
    assign clr   = redir || (state_q == HALTED && id_if.id_valid && id_if.id_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis    = |pc_q[1:0];
    assign target = redirect_pc_i;
    assign id_if.id_misalign = mis_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mis_q <= 1'b0;
        else if (redir) mis_q <= 1'b0;
        else if (load) mis_q <= mis;
`else
    assign mis    = 1'b0;
    assign target = redirect_pc_i & ~XLEN'(3);
`endif

    // A misaligned fetch captures a NOP and freezes the PC so the trap PC stays visible.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (redir) begin
            pc_d    = target;
            state_d = RUN;
        end else if (load) begin
            pc_d    = mis ? pc_q : pc_q + XLEN'(4);
            state_d = (halt_req_i || mis) ? HALTED : RUN;
        end else if (state_q == HALTED && !halt_req_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end

    assign imem_addr_o = pc_q;
    assign halted_o    = state_q == HALTED;

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .clr_i      (clr),
        .pc_i       (pc_q),
        .instr_i    (mis ? XLEN'(NOP_INSTR) : imem_instr_i),
        .pc_plus4_i (pc_q + XLEN'(4)),
        .valid_o    (id_if.id_valid),
        .pc_o       (id_if.id_pc),
        .instr_o    (id_if.id_instr),
        .pc_plus4_o (id_if.id_pc_plus4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random stimulus against a transaction-level fetch model with a scoreboard queue.
module tb_fetch_stage;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        mis;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr, redirect_pc;
    logic        redirect_valid, halt_req, halted, rdy;
    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    item_t       q[$];
    logic [31:0] m_pc;
    bit          m_boot, m_valid, m_halted;

    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) id_if ();

    assign imem_instr     = mem[imem_addr[11:2]];
    assign id_if.id_ready = rdy;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .halt_req_i       (halt_req),
        .halted_o         (halted),
        .id_if            (id_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted IF/ID word must match the oldest predicted fetch.
    always @(negedge clk)
        if (rst_n && id_if.id_valid && rdy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got pc %h expected no instruction", id_if.id_pc);
            end else begin
                item_t e;
                e = q.pop_front();
                chk("acc_pc", id_if.id_pc, e.pc);
                chk("acc_instr", id_if.id_instr, e.instr);
                chk("acc_pc4", id_if.id_pc_plus4, e.pc4);
`ifdef FETCH_MISALIGN_TRAP_EN
                chk("acc_misalign", 32'(id_if.id_misalign), 32'(e.mis));
`endif
            end
        end

    // Reference model: one transition per clock, written from the fetch rules.
    task automatic model(input bit rdv, input logic [31:0] rpc, input bit halt, input bit r);
        bit mis;
        if (m_boot) begin
            m_boot = 0;
        end else if (rdv) begin
            if (m_valid && !r) void'(q.pop_back());
            m_valid  = 0;
            m_halted = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = rpc;
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else if (!m_halted) begin
            if (!m_valid || r) begin
                mis = m_pc[1:0] != 2'b00;
                q.push_back('{m_pc, mis ? NOP_INSTR : mem[m_pc[11:2]], m_pc + 32'd4, mis});
                m_valid = 1;
                if (!mis) m_pc = m_pc + 32'd4;
                if (halt || mis) m_halted = 1;
            end
        end else begin
            if (m_valid && r) m_valid = 0;
            if (!halt) m_halted = 0;
        end
    endtask

    task automatic step(input bit rdv, input logic [31:0] rpc, input bit halt, input bit r);
        redirect_valid = rdv;
        redirect_pc    = rpc;
        halt_req       = halt;
        rdy            = r;
        model(rdv, rpc, halt, r);
        @(posedge clk);
        #2;
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", 32'(id_if.id_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL held_item: got pc %h expected a predicted instruction", id_if.id_pc);
            end else begin
                chk("held_pc", id_if.id_pc, q[$].pc);
                chk("held_instr", id_if.id_instr, q[$].instr);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        rdy            = 1'b0;
        #1;
        chk("rst_id_valid", 32'(id_if.id_valid), 32'd0);
        chk("rst_id_pc", id_if.id_pc, 32'd0);
        chk("rst_id_instr", id_if.id_instr, NOP_INSTR);
        chk("rst_id_pc4", id_if.id_pc_plus4, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        q.delete();
        m_pc = 32'd0;
        m_boot = 1;
        m_valid = 0;
        m_halted = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        do_reset();
        // Boot cycle then A, B, C back to back.
        step(0, 0, 0, 1);
        chk("boot_valid", 32'(id_if.id_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("t1_pc0", id_if.id_pc, 32'h0);
        step(0, 0, 0, 1);
        chk("t1_pc4", id_if.id_pc, 32'h4);
        // Stall holding B.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("t2_hold_addr", imem_addr, 32'h8);
        step(0, 0, 0, 1);
        chk("t2_c_pc", id_if.id_pc, 32'h8);
        step(0, 0, 0, 1);
        // Redirect while stalled kills the in-flight word.
        step(1, 32'h40, 0, 0);
        chk("t3_valid", 32'(id_if.id_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("t3_pc", id_if.id_pc, 32'h40);
        chk("t3_pc4", id_if.id_pc_plus4, 32'h44);
        // Halt at 0x10, resume at 0x14.
        step(1, 32'h10, 0, 1);
        step(0, 0, 1, 1);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_pc", id_if.id_pc, 32'h10);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("t4_drop", 32'(id_if.id_valid), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t4_resume", id_if.id_pc, 32'h14);
        // Wrap at top of address space.
        step(1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 1);
        chk("t5_pc", id_if.id_pc, 32'hFFFF_FFFC);
        chk("t5_pc4", id_if.id_pc_plus4, 32'h0);
        step(0, 0, 0, 1);
        chk("t5_wrap", id_if.id_pc, 32'h0);
        // Redirect and halt together: redirect wins.
        step(1, 32'h80, 1, 1);
        chk("rh_halted", 32'(halted), 32'd0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Misaligned redirect target.
        step(1, 32'h42, 0, 1);
        step(0, 0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_misalign", 32'(id_if.id_misalign), 32'd1);
        chk("t6_nop", id_if.id_instr, NOP_INSTR);
        chk("t6_halted", 32'(halted), 32'd1);
`else
        chk("t6_pc", id_if.id_pc, 32'h40);
`endif
        step(0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] t;
            t = ($urandom % 16 == 0) ? 32'hFFFF_FFF0 + 32'($urandom % 16)
                                     : 32'($urandom_range(0, 1023));
            if (n == 300) do_reset();
            step($urandom % 8 == 0, t, $urandom % 6 == 0, $urandom % 4 != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
